text_write_scheduler: RTL and testbench

//  Sequences all CPU writes into the character RAM's CPU port. Buffers writes in a FIFO.

---
 rtl/text_write_scheduler_pkg.sv | 24 ++
 rtl/text_write_scheduler_if.sv | 26 ++
 rtl/text_write_scheduler_fifo.sv | 65 ++++++
 rtl/text_write_scheduler.sv | 141 ++++++++++++++
 tb/tb_text_write_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_write_scheduler_pkg.sv
// Shared types and default geometry for the text-mode write path.
package text_write_scheduler_pkg;

    localparam int DEF_N_COL          = 240;
    localparam int DEF_N_ROW          = 67;
    localparam int DEF_TEXTADDR_WIDTH = 14;
    localparam int DEF_FIFO_DEPTH     = 16;

    typedef struct packed {
        logic [7:0] attr;
        logic [7:0] chr;
    } text_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } sched_state_t;

    function automatic int cell_count(input int cols, input int rows);
        return cols * rows;
    endfunction

endpackage

// File: rtl/text_write_scheduler_if.sv
// CPU-side write and clear handshake into the text write scheduler.
interface text_write_scheduler_if
    import text_write_scheduler_pkg::*;
#(
    parameter int TW = DEF_TEXTADDR_WIDTH
) ();

    logic          wr_valid;
    logic          wr_ready;
    logic [TW-1:0] wr_addr;
    text_word_t    wr_data;
    logic          clr_req;
    text_word_t    clr_data;
    logic          clr_busy;

    modport master (
        output wr_valid, wr_addr, wr_data, clr_req, clr_data,
        input  wr_ready, clr_busy
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, clr_req, clr_data,
        output wr_ready, clr_busy
    );

endinterface

// File: rtl/text_write_scheduler_fifo.sv
// Synchronous {addr, data} write queue with flush; a flush keeps a same-cycle push.
module text_wr_fifo
    import text_write_scheduler_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int AW    = DEF_TEXTADDR_WIDTH,
    parameter int PW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  text_word_t    push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [AW-1:0] pop_addr,
    output text_word_t    pop_data,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [AW-1:0] addr_mem [DEPTH];
    text_word_t    data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_idx;
    logic [LW-1:0] level_nxt;

    // After a flush the surviving push lands in slot 0 so it becomes the head.
    assign wr_idx    = flush ? '0 : wr_ptr;
    assign level_nxt = flush ? LW'(push) : level + LW'(push) - LW'(pop);
    assign pop_addr  = addr_mem[rd_ptr];
    assign pop_data  = data_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_idx] <= push_addr;
            data_mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= push ? PW'(1) : '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

endmodule

// File: rtl/text_write_scheduler.sv
// Sequences CPU writes and a full-screen clear into the characterRAM CPU port,
// optionally holding commits until vertical blanking.
module text_write_scheduler
    import text_write_scheduler_pkg::*;
#(
    parameter int N_COL          = DEF_N_COL,
    parameter int N_ROW          = DEF_N_ROW,
    parameter int TEXTADDR_WIDTH = DEF_TEXTADDR_WIDTH,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int LW             = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                      cpu_clk,
    input  logic                      rst_n,
    input  logic                      gate_en,
    input  logic                      vBlank,
    text_write_scheduler_if.slave     bus,
    output logic                      ram_we,
    output logic [TEXTADDR_WIDTH-1:0] ram_addr,
    output logic [15:0]               ram_data,
    output logic [LW-1:0]             fifo_level,
    output logic                      err_oob
);

    localparam int                      CELLS     = cell_count(N_COL, N_ROW);
    localparam logic [TEXTADDR_WIDTH:0] CELLS_EXT = (TEXTADDR_WIDTH + 1)'(CELLS);
    localparam logic [TEXTADDR_WIDTH-1:0] LAST_CELL = TEXTADDR_WIDTH'(CELLS - 1);

    sched_state_t              state;
    logic                      vb_p0;
    logic                      vb_s;
    logic                      window;
    logic                      run;
    logic                      clr_pending;
    text_word_t                clr_word;
    logic [TEXTADDR_WIDTH-1:0] clr_addr;

    logic                      ready;
    logic                      accept;
    logic                      in_range;
    logic                      push;
    logic                      pop;
    logic [TEXTADDR_WIDTH-1:0] fifo_addr;
    text_word_t                fifo_data;
    logic                      fifo_full;
    logic                      fifo_empty;

    assign window   = !gate_en || vb_s;
    assign ready    = run && !fifo_full;
    assign accept   = bus.wr_valid && ready;
    assign in_range = {1'b0, bus.wr_addr} < CELLS_EXT;
    assign push     = accept && in_range;
    // A clear request discards everything queued before it, so no pop that cycle.
    assign pop      = (state == DRAIN) && window && !fifo_empty && !clr_pending && !bus.clr_req;

    assign bus.wr_ready = ready;
    assign bus.clr_busy = clr_pending;

    text_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (TEXTADDR_WIDTH)
    ) u_fifo (
        .clk       (cpu_clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (bus.wr_addr),
        .push_data (bus.wr_data),
        .pop       (pop),
        .flush     (bus.clr_req),
        .pop_addr  (fifo_addr),
        .pop_data  (fifo_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge cpu_clk) begin
        if (bus.clr_req) clr_word <= bus.clr_data;
    end

    always_ff @(posedge cpu_clk) begin
        if (!rst_n) begin
            vb_p0       <= 1'b0;
            vb_s        <= 1'b0;
            run         <= 1'b0;
            state       <= IDLE;
            clr_pending <= 1'b0;
            clr_addr    <= '0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_data    <= '0;
            err_oob     <= 1'b0;
        end else begin
            vb_p0  <= vBlank;
            vb_s   <= vb_p0;
            run    <= 1'b1;
            ram_we <= 1'b0;

            if (accept && !in_range) err_oob <= 1'b1;

            if (bus.clr_req) begin
                clr_pending <= 1'b1;
                clr_addr    <= '0;
            end

            unique case (state)
                IDLE: begin
                    if (clr_pending && window)
                        state <= CLEAR;
                    else if (!clr_pending && !fifo_empty && window)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (pop) begin
                        ram_we   <= 1'b1;
                        ram_addr <= fifo_addr;
                        ram_data <= fifo_data;
                    end
                    if (clr_pending || bus.clr_req || !window || fifo_empty ||
                        (pop && !push && fifo_level == LW'(1)))
                        state <= IDLE;
                end
                CLEAR: begin
                    // A new clr_req restarts at cell 0; the write slot that cycle is skipped.
                    if (!bus.clr_req && window) begin
                        ram_we   <= 1'b1;
                        ram_addr <= clr_addr;
                        ram_data <= clr_word;
                        if (clr_addr == LAST_CELL) begin
                            state       <= IDLE;
                            clr_pending <= 1'b0;
                        end else begin
                            clr_addr <= clr_addr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_write_scheduler.sv
// Directed bench for text_write_scheduler: immediate, gated, clear and reset scenarios.
module tb_text_write_scheduler;
    import text_write_scheduler_pkg::*;

    localparam int TW    = 14;
    localparam int CELLS = 16080;

    logic          cpu_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic          gate_en = 1'b0;
    logic          vBlank  = 1'b0;
    logic          ram_we;
    logic [TW-1:0] ram_addr;
    logic [15:0]   ram_data;
    logic [4:0]    fifo_level;
    logic          err_oob;

    text_write_scheduler_if #(.TW(TW)) bus ();

    text_write_scheduler #(
        .N_COL          (240),
        .N_ROW          (67),
        .TEXTADDR_WIDTH (TW),
        .FIFO_DEPTH     (16)
    ) dut (
        .cpu_clk    (cpu_clk),
        .rst_n      (rst_n),
        .gate_en    (gate_en),
        .vBlank     (vBlank),
        .bus        (bus),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .fifo_level (fifo_level),
        .err_oob    (err_oob)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [TW-1:0] addr;
        logic [15:0]   data;
        int            cyc;
    } cap_t;

    cap_t cap_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    // Edge counter plus capture of every RAM write strobe, sampled just after the edge.
    always @(posedge cpu_clk) begin
        cyc = cyc + 1;
        #1;
        if (ram_we === 1'b1) cap_q.push_back('{ram_addr, ram_data, cyc});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want summary");
        $fatal(1);
    end

    task automatic push_wr(input logic [TW-1:0] a, input logic [15:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        @(negedge cpu_clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge cpu_clk);
        n_cmp++; if (ram_we !== 1'b0)     begin n_fail++; $display("FAIL reset_ram_we: got %0b want 0", ram_we); end
        n_cmp++; if (ram_addr !== '0)     begin n_fail++; $display("FAIL reset_ram_addr: got %0d want 0", ram_addr); end
        n_cmp++; if (ram_data !== 16'h0)  begin n_fail++; $display("FAIL reset_ram_data: got %h want 0", ram_data); end
        n_cmp++; if (bus.clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_clr_busy: got %0b want 0", bus.clr_busy); end
        n_cmp++; if (err_oob !== 1'b0)    begin n_fail++; $display("FAIL reset_err_oob: got %0b want 0", err_oob); end
        n_cmp++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_cmp++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %0b want 0", bus.wr_ready); end
        rst_n = 1'b1;
        @(negedge cpu_clk);
        n_cmp++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %0b want 1", bus.wr_ready); end
    endtask

    task automatic test_immediate();
        int t;
        gate_en = 1'b0;
        repeat (3) @(negedge cpu_clk);
        cap_q.delete();
        t = cyc + 1;
        push_wr(TW'(5), 16'h1F41);
        repeat (4) @(negedge cpu_clk);
        n_cmp++; if (cap_q.size() !== 1) begin n_fail++; $display("FAIL imm_count: got %0d want 1", cap_q.size()); end
        if (cap_q.size() > 0) begin
            n_cmp++; if (cap_q[0].cyc !== t + 2) begin n_fail++; $display("FAIL imm_latency: got edge %0d want %0d", cap_q[0].cyc, t + 2); end
            n_cmp++; if (cap_q[0].addr !== TW'(5)) begin n_fail++; $display("FAIL imm_addr: got %0d want 5", cap_q[0].addr); end
            n_cmp++; if (cap_q[0].data !== 16'h1F41) begin n_fail++; $display("FAIL imm_data: got %h want 1f41", cap_q[0].data); end
        end
        n_cmp++; if (ram_addr !== TW'(5)) begin n_fail++; $display("FAIL imm_addr_hold: got %0d want 5", ram_addr); end
    endtask

    task automatic test_back_to_back();
        cap_q.delete();
        for (int i = 0; i < 16; i++) push_wr(TW'(100 + i), 16'(32'hA000 + i));
        repeat (6) @(negedge cpu_clk);
        n_cmp++; if (cap_q.size() !== 16) begin n_fail++; $display("FAIL b2b_count: got %0d want 16", cap_q.size()); end
        if (cap_q.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (cap_q[i].addr !== TW'(100 + i) || cap_q[i].data !== 16'(32'hA000 + i) ||
                    cap_q[i].cyc !== cap_q[0].cyc + i) begin
                    n_fail++;
                    $display("FAIL b2b_entry%0d: got addr %0d data %h edge %0d want addr %0d data %h edge %0d",
                             i, cap_q[i].addr, cap_q[i].data, cap_q[i].cyc, 100 + i, 16'(32'hA000 + i), cap_q[0].cyc + i);
                end
            end
        end
    endtask

    task automatic test_gated();
        int r;
        gate_en = 1'b1;
        vBlank  = 1'b0;
        repeat (3) @(negedge cpu_clk);
        cap_q.delete();
        for (int i = 0; i < 16; i++) push_wr(TW'(200 + i), 16'(32'hB000 + i));
        n_cmp++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL gated_level: got %0d want 16", fifo_level); end
        n_cmp++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL gated_ready: got %0b want 0", bus.wr_ready); end
        n_cmp++; if (cap_q.size() !== 0) begin n_fail++; $display("FAIL gated_no_we: got %0d writes want 0", cap_q.size()); end
        bus.wr_valid = 1'b1;
        bus.wr_addr  = TW'(999);
        bus.wr_data  = 16'hFFFF;
        repeat (3) @(negedge cpu_clk);
        bus.wr_valid = 1'b0;
        n_cmp++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL gated_stall_level: got %0d want 16", fifo_level); end
        vBlank = 1'b1;
        r = cyc;
        for (int k = 0; k < 10 && cap_q.size() == 0; k++) @(negedge cpu_clk);
        n_cmp++;
        if (cap_q.size() == 0 || cap_q[0].cyc < r + 2 || cap_q[0].cyc > r + 4) begin
            n_fail++;
            $display("FAIL gated_start: got %0d writes first edge %0d want first edge in %0d..%0d",
                     cap_q.size(), (cap_q.size() > 0) ? cap_q[0].cyc : -1, r + 2, r + 4);
        end
        repeat (20) @(negedge cpu_clk);
        n_cmp++; if (cap_q.size() !== 16) begin n_fail++; $display("FAIL gated_count: got %0d want 16", cap_q.size()); end
        if (cap_q.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (cap_q[i].addr !== TW'(200 + i) || cap_q[i].data !== 16'(32'hB000 + i)) begin
                    n_fail++;
                    $display("FAIL gated_entry%0d: got addr %0d data %h want addr %0d data %h",
                             i, cap_q[i].addr, cap_q[i].data, 200 + i, 16'(32'hB000 + i));
                end
            end
        end
        vBlank = 1'b0;
        repeat (4) @(negedge cpu_clk);
    endtask

    task automatic test_window_drop();
        int d;
        cap_q.delete();
        for (int i = 0; i < 16; i++) push_wr(TW'(300 + i), 16'(32'hC000 + i));
        vBlank = 1'b1;
        for (int k = 0; k < 20 && cap_q.size() < 2; k++) @(negedge cpu_clk);
        vBlank = 1'b0;
        d = cyc;
        repeat (6) @(negedge cpu_clk);
        n_cmp++; if (cap_q.size() !== 4) begin n_fail++; $display("FAIL drop_count: got %0d want 4", cap_q.size()); end
        n_cmp++; if (fifo_level !== 5'd12) begin n_fail++; $display("FAIL drop_level: got %0d want 12", fifo_level); end
        n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL drop_we: got %0b want 0", ram_we); end
        n_cmp++;
        if (cap_q.size() == 0 || cap_q[$].cyc > d + 3) begin
            n_fail++;
            $display("FAIL drop_stop: got last edge %0d want <= %0d", (cap_q.size() > 0) ? cap_q[$].cyc : -1, d + 3);
        end
        vBlank = 1'b1;
        repeat (25) @(negedge cpu_clk);
        n_cmp++; if (cap_q.size() !== 16) begin n_fail++; $display("FAIL resume_count: got %0d want 16", cap_q.size()); end
        if (cap_q.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (cap_q[i].addr !== TW'(300 + i) || cap_q[i].data !== 16'(32'hC000 + i)) begin
                    n_fail++;
                    $display("FAIL resume_entry%0d: got addr %0d data %h want addr %0d data %h",
                             i, cap_q[i].addr, cap_q[i].data, 300 + i, 16'(32'hC000 + i));
                end
            end
        end
        vBlank = 1'b0;
        repeat (4) @(negedge cpu_clk);
    endtask

    task automatic test_clear();
        int bad;
        gate_en = 1'b1;
        vBlank  = 1'b0;
        cap_q.delete();
        for (int i = 0; i < 3; i++) push_wr(TW'(400 + i), 16'(32'h1100 + i));
        bus.clr_req  = 1'b1;
        bus.clr_data = 16'h0720;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = TW'(7);
        bus.wr_data  = 16'h0E58;
        @(negedge cpu_clk);
        bus.clr_req  = 1'b0;
        bus.wr_valid = 1'b0;
        n_cmp++; if (bus.clr_busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy_set: got %0b want 1", bus.clr_busy); end
        n_cmp++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL clr_flush_level: got %0d want 1", fifo_level); end
        vBlank = 1'b1;
        for (int k = 0; k < 17000 && bus.clr_busy === 1'b1; k++) @(negedge cpu_clk);
        n_cmp++; if (bus.clr_busy !== 1'b0) begin n_fail++; $display("FAIL clr_done: got busy %0b want 0", bus.clr_busy); end
        repeat (10) @(negedge cpu_clk);
        n_cmp++; if (cap_q.size() !== CELLS + 1) begin n_fail++; $display("FAIL clr_count: got %0d want %0d", cap_q.size(), CELLS + 1); end
        bad = 0;
        for (int i = 0; i < CELLS && i < cap_q.size(); i++)
            if (cap_q[i].addr !== TW'(i) || cap_q[i].data !== 16'h0720) bad++;
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL clr_cells: got %0d wrong cells want 0", bad); end
        if (cap_q.size() == CELLS + 1) begin
            n_cmp++;
            if (cap_q[CELLS].addr !== TW'(7) || cap_q[CELLS].data !== 16'h0E58) begin
                n_fail++;
                $display("FAIL clr_after_write: got addr %0d data %h want addr 7 data 0e58", cap_q[CELLS].addr, cap_q[CELLS].data);
            end
        end
        vBlank  = 1'b0;
        gate_en = 1'b0;
        repeat (4) @(negedge cpu_clk);
    endtask

    task automatic test_clear_restart();
        int bad;
        gate_en = 1'b0;
        cap_q.delete();
        bus.clr_req  = 1'b1;
        bus.clr_data = 16'h1111;
        @(negedge cpu_clk);
        bus.clr_req = 1'b0;
        for (int k = 0; k < 200 && !(cap_q.size() > 0 && cap_q[$].addr == TW'(100)); k++) @(negedge cpu_clk);
        bus.clr_req  = 1'b1;
        bus.clr_data = 16'h2222;
        @(negedge cpu_clk);
        bus.clr_req = 1'b0;
        for (int k = 0; k < 17000 && bus.clr_busy === 1'b1; k++) @(negedge cpu_clk);
        n_cmp++; if (cap_q.size() !== 101 + CELLS) begin n_fail++; $display("FAIL restart_count: got %0d want %0d", cap_q.size(), 101 + CELLS); end
        if (cap_q.size() == 101 + CELLS) begin
            n_cmp++;
            if (cap_q[$].addr !== TW'(CELLS - 1) || cap_q[$].data !== 16'h2222) begin
                n_fail++;
                $display("FAIL restart_busy_end: got last addr %0d data %h want addr %0d data 2222", cap_q[$].addr, cap_q[$].data, CELLS - 1);
            end
            n_cmp++;
            if (cap_q[100].addr !== TW'(100) || cap_q[100].data !== 16'h1111) begin
                n_fail++;
                $display("FAIL restart_first_phase: got addr %0d data %h want addr 100 data 1111", cap_q[100].addr, cap_q[100].data);
            end
            bad = 0;
            for (int i = 0; i < CELLS; i++)
                if (cap_q[101 + i].addr !== TW'(i) || cap_q[101 + i].data !== 16'h2222) bad++;
            n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL restart_cells: got %0d wrong cells want 0", bad); end
        end
        repeat (4) @(negedge cpu_clk);
    endtask

    task automatic test_oob_and_reset();
        int n;
        gate_en = 1'b0;
        cap_q.delete();
        push_wr(TW'(CELLS), 16'h1234);
        repeat (5) @(negedge cpu_clk);
        n_cmp++; if (cap_q.size() !== 0) begin n_fail++; $display("FAIL oob_dropped: got %0d writes want 0", cap_q.size()); end
        n_cmp++; if (err_oob !== 1'b1) begin n_fail++; $display("FAIL oob_flag: got %0b want 1", err_oob); end
        push_wr(TW'(CELLS - 1), 16'h5678);
        repeat (5) @(negedge cpu_clk);
        n_cmp++;
        if (cap_q.size() !== 1 || cap_q[0].addr !== TW'(CELLS - 1) || cap_q[0].data !== 16'h5678) begin
            n_fail++;
            $display("FAIL oob_last_cell: got %0d writes addr %0d want 1 write addr %0d",
                     cap_q.size(), (cap_q.size() > 0) ? cap_q[0].addr : '0, CELLS - 1);
        end
        bus.clr_req  = 1'b1;
        bus.clr_data = 16'h0F00;
        @(negedge cpu_clk);
        bus.clr_req = 1'b0;
        repeat (40) @(negedge cpu_clk);
        n_cmp++; if (err_oob !== 1'b1) begin n_fail++; $display("FAIL oob_sticky: got %0b want 1", err_oob); end
        n_cmp++; if (bus.clr_busy !== 1'b1) begin n_fail++; $display("FAIL midclr_busy: got %0b want 1", bus.clr_busy); end
        rst_n = 1'b0;
        @(negedge cpu_clk);
        n = cap_q.size();
        n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL midclr_rst_we: got %0b want 0", ram_we); end
        n_cmp++; if (bus.clr_busy !== 1'b0) begin n_fail++; $display("FAIL midclr_rst_busy: got %0b want 0", bus.clr_busy); end
        n_cmp++; if (err_oob !== 1'b0) begin n_fail++; $display("FAIL rst_err_oob: got %0b want 0", err_oob); end
        rst_n = 1'b1;
        repeat (10) @(negedge cpu_clk);
        n_cmp++; if (cap_q.size() !== n) begin n_fail++; $display("FAIL midclr_abandon: got %0d writes want %0d", cap_q.size(), n); end
        n_cmp++; if (bus.clr_busy !== 1'b0) begin n_fail++; $display("FAIL midclr_idle_busy: got %0b want 0", bus.clr_busy); end
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.clr_req  = 1'b0;
        bus.clr_data = '0;
        @(negedge cpu_clk);
        test_reset();
        test_immediate();
        test_back_to_back();
        test_gated();
        test_window_drop();
        test_clear();
        test_clear_restart();
        test_oob_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
